// File: rtl/btn_conditioner_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : btn_conditioner_pkg                                             |
// | Brief    : Shared types for the button conditioner (per-button FSM states)  |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
package btn_conditioner_pkg;

  // Per-button press/repeat state. Encodings are fixed so that they match the
  // values the game controller team uses in their debug views.
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_RPT = 2'd1,
    ST_REPEAT   = 2'd2
  } btn_state_e;

endpackage
`default_nettype wire

// File: rtl/btn_conditioner_debounce.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : btn_conditioner_debounce                                        |
// | Brief    : One button: 2-FF synchroniser, debouncer, press/repeat FSM.     |
// |            Emits a combinational candidate that the top registers.         |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module btn_conditioner_debounce
  import btn_conditioner_pkg::*;
#(
  parameter int unsigned DEB_CYCLES   = 20,
  parameter int unsigned REPEAT_DELAY = 500,
  parameter int unsigned REPEAT_RATE  = 100,
  parameter int unsigned CNT_W        = 16
) (
  input  logic clk_d,
  input  logic rst,
  input  logic btn_i,
  input  logic repeat_en_i,
  output logic held_o,
  output logic cand_o
);

  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);
  // Arming needs the synchroniser flushed (2 samples) plus a full debounce
  // window of released samples, so a button held through reset never arms.
  localparam logic [CNT_W-1:0] ARM_LAST = CNT_W'(DEB_CYCLES + 1);
  localparam logic [CNT_W-1:0] RPT_DLY  = CNT_W'(REPEAT_DELAY);
  localparam logic [CNT_W-1:0] RPT_RATE = CNT_W'(REPEAT_RATE);

  logic             sync1_q;
  logic             sync2_q;
  logic             held_q;
  logic             held_d;
  logic [CNT_W-1:0] deb_cnt_q;
  logic [CNT_W-1:0] deb_cnt_d;
  logic             arm_q;
  logic [CNT_W-1:0] arm_cnt_q;
  btn_state_e       state_q;
  logic [CNT_W-1:0] rpt_cnt_q;

  // Two-stage synchroniser for the asynchronous raw level.
  always_ff @(posedge clk_d or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
    end
  end

  // Debounce next-state: count consecutive disagreements, accept on the last one.
  always_comb begin
    held_d    = held_q;
    deb_cnt_d = '0;
    if (sync2_q != held_q) begin
      if (deb_cnt_q >= DEB_LAST) begin
        held_d    = sync2_q;
        deb_cnt_d = '0;
      end else begin
        deb_cnt_d = deb_cnt_q + ONE;
      end
    end
  end

  // Debounced level and its run counter.
  always_ff @(posedge clk_d or negedge rst) begin
    if (!rst) begin
      held_q    <= 1'b0;
      deb_cnt_q <= '0;
    end else begin
      held_q    <= held_d;
      deb_cnt_q <= deb_cnt_d;
    end
  end

  // Arm the button once it has been seen released long enough after reset.
  always_ff @(posedge clk_d or negedge rst) begin
    if (!rst) begin
      arm_q     <= 1'b0;
      arm_cnt_q <= '0;
    end else if (!arm_q) begin
      if (sync2_q) begin
        arm_cnt_q <= '0;
      end else if (arm_cnt_q >= ARM_LAST) begin
        arm_q <= 1'b1;
      end else begin
        arm_cnt_q <= arm_cnt_q + ONE;
      end
    end
  end

  // Press / auto-repeat FSM with its repeat interval counter.
  always_ff @(posedge clk_d or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      rpt_cnt_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (held_q && arm_q) begin
            state_q   <= ST_WAIT_RPT;
            rpt_cnt_q <= ONE;
          end
        end
        ST_WAIT_RPT: begin
          if (!held_q) begin
            state_q   <= ST_IDLE;
            rpt_cnt_q <= '0;
          end else if (!repeat_en_i) begin
            rpt_cnt_q <= '0;
          end else if (rpt_cnt_q >= RPT_DLY) begin
            state_q   <= ST_REPEAT;
            rpt_cnt_q <= ONE;
          end else begin
            rpt_cnt_q <= rpt_cnt_q + ONE;
          end
        end
        ST_REPEAT: begin
          if (!held_q) begin
            state_q   <= ST_IDLE;
            rpt_cnt_q <= '0;
          end else if (!repeat_en_i) begin
            rpt_cnt_q <= '0;
          end else if (rpt_cnt_q >= RPT_RATE) begin
            rpt_cnt_q <= ONE;
          end else begin
            rpt_cnt_q <= rpt_cnt_q + ONE;
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          rpt_cnt_q <= '0;
        end
      endcase
    end
  end

  // Candidate decode; a release always wins over a due repeat.
  always_comb begin
    cand_o = 1'b0;
    case (state_q)
      ST_IDLE:     cand_o = held_q & arm_q;
      ST_WAIT_RPT: cand_o = held_q & repeat_en_i & (rpt_cnt_q >= RPT_DLY);
      ST_REPEAT:   cand_o = held_q & repeat_en_i & (rpt_cnt_q >= RPT_RATE);
      default:     cand_o = 1'b0;
    endcase
  end

  assign held_o = held_q;

endmodule
`default_nettype wire

// File: rtl/btn_conditioner.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : btn_conditioner                                                 |
// | Brief    : Per-button conditioning plus lowest-index priority arbiter that |
// |            produces one-hot, one-cycle press flags for the controller.     |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module btn_conditioner
  import btn_conditioner_pkg::*;
#(
  parameter int unsigned N_BTN        = 5,
  parameter int unsigned DEB_CYCLES   = 20,
  parameter int unsigned REPEAT_DELAY = 500,
  parameter int unsigned REPEAT_RATE  = 100,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk_d,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_raw,
  input  logic             repeat_en,
  output logic [N_BTN-1:0] flag,
  output logic [N_BTN-1:0] held,
  output logic             multi_err
);

  logic [N_BTN-1:0] cand;
  logic [N_BTN-1:0] flag_d;
  logic             multi_err_d;
  logic [N_BTN-1:0] flag_q;
  logic             multi_err_q;

  // Isolate the lowest set bit (two's-complement trick).
  function automatic logic [N_BTN-1:0] lowest_set(input logic [N_BTN-1:0] v);
    return v & (~v + N_BTN'(1));
  endfunction

  // True when clearing the lowest set bit still leaves something set.
  function automatic logic more_than_one(input logic [N_BTN-1:0] v);
    return (v & (v - N_BTN'(1))) != '0;
  endfunction

  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    btn_conditioner_debounce #(
      .DEB_CYCLES   (DEB_CYCLES),
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_RATE  (REPEAT_RATE),
      .CNT_W        (CNT_W)
    ) u_btn (
      .clk_d       (clk_d),
      .rst         (rst),
      .btn_i       (btn_raw[i]),
      .repeat_en_i (repeat_en),
      .held_o      (held[i]),
      .cand_o      (cand[i])
    );
  end

  // Arbitration: lowest index wins, losers are dropped.
  always_comb begin
    flag_d      = lowest_set(cand);
    multi_err_d = more_than_one(cand);
  end

  // Output registers; async reset drops the flags immediately.
  always_ff @(posedge clk_d or negedge rst) begin
    if (!rst) begin
      flag_q      <= '0;
      multi_err_q <= 1'b0;
    end else begin
      flag_q      <= flag_d;
      multi_err_q <= multi_err_d;
    end
  end

  assign flag      = flag_q;
  assign multi_err = multi_err_q;

endmodule
`default_nettype wire
